// File: rtl/alu_pkg.sv
// Shared types and constants for the execute stage: ALU op codes, branch funct3, EX/MEM register layout.
// No logic; widths here must match the XLEN/REG_ADDR_W the stage is built with.
// No handshake of its own.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0010,
    ALU_OR     = 4'b0011,
    ALU_SLTU_B = 4'b0100,
    ALU_SLT    = 4'b0101,
    ALU_SLL    = 4'b0110,
    ALU_SLTU   = 4'b0111,
    ALU_XOR    = 4'b1000,
    ALU_SRL    = 4'b1110,
    ALU_SRA    = 4'b1111
  } alu_ctrl_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic              reg_write;
    logic              branch_taken;
    logic [DATA_W-1:0] branch_target;
  } ex_mem_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: result = op(a, b) selected by alu_control; unknown codes yield 0.
// Latency: 0 cycles (purely combinational).
// Backpressure: none, output follows inputs.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = DATA_W
) (
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  alu_ctrl_t op;
  logic [4:0] shamt;

  assign op    = alu_ctrl_t'(alu_control);
  assign shamt = b[4:0];

  // Operation select; both unsigned-compare encodings map to the same comparator.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:             result = a + b;
      ALU_SUB:             result = a - b;
      ALU_AND:             result = a & b;
      ALU_OR:              result = a | b;
      ALU_XOR:             result = a ^ b;
      ALU_SLT:             result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU, ALU_SLTU_B: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLL:             result = a << shamt;
      ALU_SRL:             result = a >> shamt;
      ALU_SRA:             result = $unsigned($signed(a) >>> shamt);
      default:             result = '0;
    endcase
  end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU op + branch resolution into a single EX/MEM output register.
// Latency: 1 cycle from accept to out_valid; full throughput with simultaneous drain+accept.
// Backpressure: in_ready = !out_valid | out_ready; outputs hold while stalled; flush kills the slot.
module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int XLEN       = DATA_W,
  parameter int REG_ADDR_W = RD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_control,
  input  logic [XLEN-1:0]       src_a,
  input  logic [XLEN-1:0]       src_b,
  input  logic                  is_branch,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       branch_target,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  reg_write,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_branch_taken,
  output logic [XLEN-1:0]       out_branch_target
);

  ex_mem_t         ex_mem;
  ex_mem_t         ex_mem_next;
  logic [XLEN-1:0] alu_result;
  logic            taken;
  logic            accept;
  logic            drain;

  assign in_ready = !ex_mem.valid | out_ready;
  assign accept   = in_valid & in_ready & !flush;
  assign drain    = ex_mem.valid & out_ready;

  alu #(.XLEN(XLEN)) u_alu (
    .alu_control (alu_control),
    .a           (src_a),
    .b           (src_b),
    .result      (alu_result)
  );

  // Branch decision reuses the ALU output: sub for eq/ne, slt/sltu for the ordered compares.
  always_comb begin
    taken = 1'b0;
    if (is_branch) begin
      case (funct3)
        F3_BEQ:           taken = (alu_result == '0);
        F3_BNE:           taken = (alu_result != '0);
        F3_BLT, F3_BLTU:  taken = (alu_result == XLEN'(1));
        F3_BGE, F3_BGEU:  taken = (alu_result == '0);
        default:          taken = 1'b0;
      endcase
    end
  end

  // Next register contents for an accepted instruction; branches never write rd.
  always_comb begin
    ex_mem_next               = '0;
    ex_mem_next.valid         = 1'b1;
    ex_mem_next.result        = alu_result;
    ex_mem_next.rd            = rd;
    ex_mem_next.reg_write     = reg_write & !is_branch;
    ex_mem_next.branch_taken  = taken;
    ex_mem_next.branch_target = branch_target;
  end

  // EX/MEM register: reset clears everything, flush only kills valid, accept overrides drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem <= '0;
    end else if (flush) begin
      ex_mem.valid <= 1'b0;
    end else if (accept) begin
      ex_mem <= ex_mem_next;
    end else if (drain) begin
      ex_mem.valid <= 1'b0;
    end
  end

  assign out_valid         = ex_mem.valid;
  assign out_result        = ex_mem.result;
  assign out_rd            = ex_mem.rd;
  assign out_reg_write     = ex_mem.reg_write;
  assign out_branch_taken  = ex_mem.branch_taken;
  assign out_branch_target = ex_mem.branch_target;

endmodule
